// File: rtl/sort_rd_prefetch.sv
// Burst-read prefetcher: fetches a contiguous block of 64-bit words from memory
// into a show-ahead FIFO and presents them on an idata/rdy/pop style handshake.
module sort_rd_prefetch #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 19,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [4:0]            mem_len,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  rdy,
  input  logic                  pop
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BL_W  = 5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [BL_W-1:0]       outstanding_q, outstanding_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BL_W-1:0]       mem_len_q, mem_len_d;

  logic [DATA_WIDTH-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic                  rdy_q, rdy_d;

  logic [BL_W-1:0]       blen_c;
  logic [CNT_W-1:0]      space_c;
  logic                  space_ok_c;
  logic                  wr_en_c;
  logic                  rd_en_c;
  logic                  stray_c;

  always_comb begin
    if (remaining_q >= LEN_WIDTH'(BURST_LEN)) blen_c = BL_W'(BURST_LEN);
    else                                      blen_c = BL_W'(remaining_q);
    space_c    = CNT_W'(DEPTH) - count_q;
    space_ok_c = 32'(space_c) >= 32'(blen_c);
    wr_en_c    = mem_rvalid && (state_q == S_WAIT);
    rd_en_c    = pop && rdy_q;
    stray_c    = mem_rvalid && (state_q != S_WAIT);
  end

  // Job control: one burst in flight, request raised only when the FIFO can absorb it.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_len_d     = mem_len_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_words != '0) begin
            addr_d      = base_addr & ~ADDR_WIDTH'(7);
            remaining_d = num_words;
            state_d     = S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (mem_req_q) begin
          if (mem_ack) begin
            mem_req_d     = 1'b0;
            addr_d        = addr_q + ADDR_WIDTH'({mem_len_q, 3'b000});
            remaining_d   = remaining_q - LEN_WIDTH'(mem_len_q);
            outstanding_d = mem_len_q;
            state_d       = S_WAIT;
          end
        end else if (space_ok_c) begin
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q;
          mem_len_d  = blen_c;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          outstanding_d = outstanding_q - BL_W'(1);
          if (outstanding_q == BL_W'(1)) begin
            state_d = (remaining_q != '0) ? S_ISSUE : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (count_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stray_c) err_d = 1'b1;
    busy_d = (state_d != S_IDLE) || done_d;
  end

  // FIFO pointers and registered show-ahead head; a write into the head slot is forwarded.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_c);
    count_d  = count_q + CNT_W'(wr_en_c) - CNT_W'(rd_en_c);
    rdy_d    = count_d != '0;
    odata_d  = odata_q;
    if (count_d != '0) begin
      if (wr_en_c && (wr_ptr_q == rd_ptr_d)) odata_d = mem_rdata;
      else                                   odata_d = fifo_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_len_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      odata_q       <= '0;
      rdy_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_len_q     <= mem_len_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      odata_q       <= odata_d;
      rdy_q         <= rdy_d;
    end
  end

  // Storage array carries no reset; only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    if (wr_en_c) fifo_q[wr_ptr_q] <= mem_rdata;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign mem_len  = mem_len_q;
  assign odata    = odata_q;
  assign rdy      = rdy_q;

endmodule

// File: tb/tb_sort_rd_prefetch.sv
// Bench for sort_rd_prefetch: reactive memory responder, queue-based reference
// model checked every cycle, and directed jobs with hand-computed expectations.
module tb_sort_rd_prefetch;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int LW    = 19;
  localparam int DEPTH = 16;
  localparam int BL    = 8;
  localparam int BIG   = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] num_words;
  logic          busy, done, err, mem_req, mem_ack, mem_rvalid, rdy, pop;
  logic [AW-1:0] mem_addr;
  logic [4:0]    mem_len;
  logic [DW-1:0] mem_rdata, odata;

  sort_rd_prefetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                     .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .odata(odata), .rdy(rdy), .pop(pop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus knobs
  int pop_mode  = 0;
  int ack_lat   = 0;
  bit gap_mode  = 1'b0;
  bit stray_req = 1'b0;
  bit beat_legit = 1'b0;

  // Responder state
  int          rs = 0;
  int          lat_cnt = 0;
  logic [31:0] r_addr = '0;
  int          r_len = 0;
  int          r_beat = 0;

  // Reference model
  int          cnt = 0;
  int          busy_from = -1;
  int          done_at = BIG;
  bit          err_exp = 1'b0;
  bit          held = 1'b0;
  logic [31:0] h_addr = '0;
  logic [4:0]  h_len = '0;
  logic [63:0] exp_words[$];
  logic [31:0] exp_ra[$];
  int          exp_rl[$];
  int          k;
  bit          exp_busy, is_stray;
  logic [31:0] m_a;
  int          m_rem, m_l;

  // Observation logs for directed checks
  logic [31:0] req_a[$];
  int          req_l[$];
  int          popped_n = 0, beats_n = 0, wp_cov = 0;
  int          last_pop_cyc = 0, done_cyc = 0, start_cyc = 0;
  bit          done_seen = 1'b0;
  logic [63:0] first_word = '0;

  function automatic logic [63:0] mk(input logic [31:0] a);
    return {~a, a};
  endfunction

  function automatic logic [31:0] ra(input int i);
    if (i < req_a.size()) return req_a[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int rl(input int i);
    if (i < req_l.size()) return req_l[i];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: acks a request after ack_lat cycles, then returns mk(addr) beats.
  initial forever begin
    @(posedge clk);
    #1;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    beat_legit = 1'b0;
    if (reset) begin
      rs = 0;
      lat_cnt = 0;
    end else if (rs == 0) begin
      if (stray_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
        stray_req  = 1'b0;
      end
      if (mem_req) begin
        if (lat_cnt >= ack_lat) begin
          mem_ack = 1'b1;
          r_addr  = mem_addr;
          r_len   = int'(mem_len);
          r_beat  = 0;
          rs      = 1;
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end
    end else if (!(gap_mode && $urandom_range(0, 2) == 0)) begin
      mem_rvalid = 1'b1;
      beat_legit = 1'b1;
      mem_rdata  = mk(r_addr + 32'(8 * r_beat));
      r_beat++;
      if (r_beat == r_len) rs = 0;
    end
    case (pop_mode)
      0:       pop = 1'b0;
      1:       pop = 1'b1;
      default: pop = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare every cycle against the job-level model.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_rdy", 64'(rdy), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_len", 64'(mem_len), 64'(0));
      chk("rst_odata", odata, 64'(0));
      cnt = 0; busy_from = -1; done_at = BIG; err_exp = 1'b0; held = 1'b0;
      exp_words.delete(); exp_ra.delete(); exp_rl.delete();
    end else begin
      k = cyc;
      exp_busy = (busy_from >= 0) && (k >= busy_from) && (k <= done_at);
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(k == done_at));
      chk("err", 64'(err), 64'(err_exp));
      chk("rdy", 64'(rdy), 64'(cnt > 0));
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = k;
      end
      if (held) begin
        chk("req_held", 64'(mem_req), 64'(1));
        chk("req_addr_stable", 64'(mem_addr), 64'(h_addr));
        chk("req_len_stable", 64'(mem_len), 64'(h_len));
      end
      if (!mem_req) held = 1'b0;
      if (mem_req && !held) begin
        chk("req_space", 64'(DEPTH - cnt >= int'(mem_len)), 64'(1));
        if (exp_ra.size() == 0) begin
          chk("req_unexpected", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("req_addr", 64'(mem_addr), 64'(exp_ra[0]));
          chk("req_len", 64'(mem_len), 64'(exp_rl[0]));
        end
        held = 1'b1; h_addr = mem_addr; h_len = mem_len;
      end
      if (mem_req && mem_ack) begin
        held = 1'b0;
        req_a.push_back(mem_addr);
        req_l.push_back(int'(mem_len));
        if (exp_ra.size() > 0) begin
          void'(exp_ra.pop_front());
          void'(exp_rl.pop_front());
        end
      end
      if (pop && rdy) begin
        if (exp_words.size() == 0) begin
          chk("word_unexpected", odata, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("odata", odata, exp_words[0]);
          if (popped_n == 0) first_word = odata;
          void'(exp_words.pop_front());
          popped_n++;
          last_pop_cyc = k;
          if (exp_words.size() == 0 && busy_from >= 0 && done_at == BIG) done_at = k + 2;
        end
      end
      is_stray = mem_rvalid && !beat_legit;
      if (mem_rvalid && beat_legit) begin
        beats_n++;
        if (pop && cnt == 1) wp_cov++;
      end
      cnt = cnt + ((mem_rvalid && beat_legit) ? 1 : 0) - ((pop && cnt > 0) ? 1 : 0);
      if (start && !((busy_from >= 0) && (k >= busy_from) && (k < done_at))) begin
        err_exp   = 1'b0;
        start_cyc = k;
        busy_from = k + 1;
        if (num_words == '0) begin
          done_at = k + 1;
        end else begin
          done_at = BIG;
          m_a   = base_addr & 32'hFFFF_FFF8;
          m_rem = int'(num_words);
          for (int i = 0; i < m_rem; i++) exp_words.push_back(mk(m_a + 32'(8 * i)));
          while (m_rem > 0) begin
            m_l = (m_rem < BL) ? m_rem : BL;
            exp_ra.push_back(m_a);
            exp_rl.push_back(m_l);
            m_a   = m_a + 32'(8 * m_l);
            m_rem = m_rem - m_l;
          end
        end
      end
      if (is_stray) err_exp = 1'b1;
    end
  end

  task automatic clear_logs();
    req_a.delete(); req_l.delete();
    popped_n = 0; beats_n = 0; wp_cov = 0; done_seen = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] a, input int n);
    @(posedge clk); #1;
    base_addr = a;
    num_words = LW'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) @(posedge clk);
    chk("done_timeout", 64'(done_seen), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic run_job(input logic [31:0] a, input int n, input int budget);
    clear_logs();
    do_start(a, n);
    wait_done(budget);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; pop = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("init_mem_req", 64'(mem_req), 64'(0));
    chk("init_odata", odata, 64'(0));
    @(posedge clk); #3 reset = 1'b0;

    // Single job with immediate memory and a consumer that always pops
    pop_mode = 1;
    run_job(32'h1000, 20, 500);
    chk("t1_nreq", 64'(req_a.size()), 64'(3));
    chk("t1_req0_a", 64'(ra(0)), 64'h1000);
    chk("t1_req0_l", 64'(rl(0)), 64'(8));
    chk("t1_req1_a", 64'(ra(1)), 64'h1040);
    chk("t1_req1_l", 64'(rl(1)), 64'(8));
    chk("t1_req2_a", 64'(ra(2)), 64'h1080);
    chk("t1_req2_l", 64'(rl(2)), 64'(4));
    chk("t1_words", 64'(popped_n), 64'(20));
    chk("t1_first", first_word, 64'hFFFF_EFFF_0000_1000);
    chk("t1_done_lat", 64'(done_cyc - last_pop_cyc), 64'(2));
    chk("t1_wr_pop_at_1", 64'(wp_cov > 0), 64'(1));

    // Zero-length job
    run_job(32'h2000, 0, 20);
    chk("t2_done_lat", 64'(done_cyc - start_cyc), 64'(1));
    chk("t2_nreq", 64'(req_a.size()), 64'(0));

    // Address wrap at the top of the space
    run_job(32'hFFFF_FFF8, 3, 200);
    chk("t3_nreq", 64'(req_a.size()), 64'(1));
    chk("t3_req0_a", 64'(ra(0)), 64'hFFFF_FFF8);
    chk("t3_req0_l", 64'(rl(0)), 64'(3));
    chk("t3_words", 64'(popped_n), 64'(3));

    // Misaligned base address
    run_job(32'h1003, 4, 200);
    chk("t4_req0_a", 64'(ra(0)), 64'h1000);
    chk("t4_req0_l", 64'(rl(0)), 64'(4));
    chk("t4_first", first_word, 64'hFFFF_EFFF_0000_1000);

    // Backpressure: consumer stalled, FIFO fills, requests stop
    pop_mode = 0;
    clear_logs();
    do_start(32'h4000, 40);
    repeat (80) @(posedge clk);
    #1;
    chk("t5_req_low", 64'(mem_req), 64'(0));
    chk("t5_beats", 64'(beats_n), 64'(16));
    chk("t5_nreq", 64'(req_a.size()), 64'(2));
    chk("t5_rdy", 64'(rdy), 64'(1));
    pop_mode = 1;
    wait_done(2000);
    chk("t5_words", 64'(popped_n), 64'(40));
    chk("t5_nreq_total", 64'(req_a.size()), 64'(5));

    // Start while busy is ignored; slow memory, gappy beats, random pops
    pop_mode = 2; ack_lat = 2; gap_mode = 1'b1;
    clear_logs();
    do_start(32'h2000, 20);
    repeat (6) @(posedge clk);
    do_start(32'h9000, 5);
    wait_done(3000);
    chk("t6_nreq", 64'(req_a.size()), 64'(3));
    chk("t6_req0_a", 64'(ra(0)), 64'h2000);
    chk("t6_req2_a", 64'(ra(2)), 64'h2080);
    chk("t6_words", 64'(popped_n), 64'(20));
    ack_lat = 0; gap_mode = 1'b0;

    // Stray beat in IDLE sets err; next accepted start clears it
    repeat (2) @(posedge clk);
    #2 stray_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_err", 64'(err), 64'(1));
    chk("t7_rdy", 64'(rdy), 64'(0));
    pop_mode = 1;
    run_job(32'h3000, 2, 200);
    chk("t7_err_clr", 64'(err), 64'(0));
    chk("t7_words", 64'(popped_n), 64'(2));

    // Reset in the middle of a burst
    pop_mode = 0;
    clear_logs();
    do_start(32'h5000, 20);
    for (int i = 0; i < 100 && beats_n < 3; i++) @(posedge clk);
    chk("t8_beats_seen", 64'(beats_n >= 3), 64'(1));
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("t8_busy", 64'(busy), 64'(0));
    chk("t8_mem_req", 64'(mem_req), 64'(0));
    chk("t8_rdy", 64'(rdy), 64'(0));
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #2 stray_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t8_err_after", 64'(err), 64'(1));
    chk("t8_rdy_after", 64'(rdy), 64'(0));
    chk("t8_done_seen", 64'(done_seen), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_rd_prefetch.md
# sort_rd_prefetch

Upstream feeder for the sort/encrypt accelerator: fetches a contiguous block of 64-bit words from memory through a burst-read master port, buffers them in a small show-ahead FIFO, and presents them on the `idata`/`rdy`/`pop` handshake the accelerator's input side consumes. One job covers `num_words` words from `base_addr`. The block reports `busy`/`done`, and a sticky `err` for protocol faults.

## Interface
- `DATA_WIDTH`, default 64: word width; fixed 8-byte words.
- `ADDR_WIDTH`, default 32: byte address width.
- `LEN_WIDTH`, default 19: job length counter width, in words.
- `DEPTH`, default 16: FIFO depth in words; power of two, must be >= `BURST_LEN`.
- `BURST_LEN`, default 8: maximum words per memory burst; power of two, at most 16.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle job start pulse.
- `base_addr` input ADDR_WIDTH: job byte address; bits [2:0] are ignored and treated as 0.
- `num_words` input LEN_WIDTH: job length in words.
- `busy` output 1: job in progress.
- `done` output 1: one-cycle pulse at job completion.
- `err` output 1: sticky; set when `mem_rvalid` arrives with no beats outstanding; cleared by an accepted `start`.
- `mem_req` output 1: burst request; held until acknowledged.
- `mem_addr` output ADDR_WIDTH: burst byte address; stable while `mem_req` is high.
- `mem_len` output 5: burst length in words, 1..BURST_LEN; stable while `mem_req` is high.
- `mem_ack` input 1: request accepted in a cycle where `mem_req` is high.
- `mem_rdata` input DATA_WIDTH: read beat data.
- `mem_rvalid` input 1: read beat valid; no backpressure.
- `odata` output DATA_WIDTH: FIFO head word (show-ahead).
- `rdy` output 1: FIFO non-empty.
- `pop` input 1: consume the head word.

## Operation
- FSM states are IDLE, ISSUE, WAIT, DRAIN.
- **IDLE**
  - Accepted `start` with `num_words != 0`: latch `addr = {base_addr[ADDR_WIDTH-1:3], 3'b0}`, set `remaining = num_words`, clear `err`, go to ISSUE.
  - Accepted `start` with `num_words == 0`: `done` pulses the next cycle; state stays IDLE.
- **ISSUE**
  - `blen = min(BURST_LEN, remaining)`.
  - `mem_req` rises only when `DEPTH - count >= blen`, where `count` is FIFO occupancy. This space reservation makes FIFO overflow impossible.
  - On `mem_req & mem_ack`:
    - `addr += blen*8`, modulo 2^ADDR_WIDTH; wrap is silent.
    - `remaining -= blen`.
    - `outstanding = blen`.
    - `mem_req` drops the next cycle; go to WAIT.
- **WAIT**
  - Each `mem_rvalid` writes `mem_rdata` to the FIFO and decrements `outstanding`.
  - When the last beat is written: go to ISSUE if `remaining != 0`, otherwise go to DRAIN.
  - Only one burst is outstanding at a time.
- **DRAIN**
  - When the FIFO is empty: pulse `done` for one cycle and go to IDLE.
- **Stray beats**
  - `mem_rvalid` in IDLE, ISSUE or DRAIN sets `err` and the data is discarded.
- **FIFO**
  - `pop` with `rdy` high advances the head.
  - `pop` with `rdy` low is ignored.
  - A write and a pop in the same cycle leave `count` unchanged.
  - There is no write-to-read bypass: a word written into an empty FIFO appears on `odata`/`rdy` the next cycle.
- **`start` while `busy`** is ignored and does not affect the running job.
- **`busy`** is high from the cycle after an accepted `start` until the cycle `done` pulses, inclusive of that cycle.

## Timing
- Reset values:
  - Outputs: `busy`, `done`, `err`, `mem_req` and `rdy` are 0; `mem_addr`, `mem_len` and `odata` are 0.
  - Internal: FIFO empty; state is IDLE.
- Reset asserted mid-job aborts immediately, with no `done` pulse; beats arriving after reset deassertion set `err`.
- All outputs are registered.
- `start` to `mem_req`: 2 cycles, since the IDLE→ISSUE transition is registered and then the request is registered.
- `mem_ack` and a beat cannot overlap: beats for a burst begin no earlier than the cycle after `mem_ack`.
- `mem_rvalid` to `rdy` on an empty FIFO: 1 cycle.
- Last pop (with `rdy` high) to `done`: 2 cycles.
- Steady-state throughput is bounded by memory latency plus one ISSUE cycle per burst.

## Test plan
- **Reset:** assert `reset` mid-burst → all outputs 0 within the same cycle; FIFO empty; a following beat sets `err`.
- **Single job:** `base_addr=0x1000`, `num_words=20`, `BURST_LEN=8`, memory returns beats immediately → requests (0x1000,8), (0x1040,8), (0x1080,4); 20 words emerge in order; `done` arrives 2 cycles after the 20th pop.
- **Backpressure:** `DEPTH=16`, `pop` held low, `num_words=40` → after 16 words `mem_req` stays low with `count=16`; releasing `pop` resumes requests; no words are lost or reordered.
- **Boundaries:**
  - `num_words=0` → `done` 1 cycle after `start`; `mem_req` never rises.
  - `base_addr=0xFFFFFFF8`, `num_words=3` → one burst (0xFFFFFFF8, len 3); the internal address wraps to 0x10 and no further request is issued.
- **Handshake corner cases:**
  - Simultaneous write and pop at `count=1` → `count` stays 1 and `odata` advances.
  - `start` pulsed while `busy` → ignored.
  - Misaligned `base_addr=0x1003` → first request at 0x1000.
- **Protocol error:** `mem_rvalid` pulsed in IDLE → `err=1` and the FIFO is unchanged; the next accepted `start` clears `err`.
